// File: rtl/enc_pkg.sv
// Shared types, widths and helpers for the enc16to4_seq serialising encoder.
package enc_pkg;

  localparam int VEC_W  = 16;
  localparam int CODE_W = 4;

  localparam logic [VEC_W-1:0]  VEC_ZERO  = 16'h0000;
  localparam logic [VEC_W-1:0]  VEC_ONE   = 16'h0001;
  localparam logic [CODE_W-1:0] CODE_ZERO = 4'h0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Even-parity bit: set when the code holds an odd number of ones.
  function automatic logic even_parity(input logic [CODE_W-1:0] code);
    return ^code;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational priority select over a 16-bit vector: index of the first set
// bit in the requested scan order, plus a flag telling whether it is the only one.
module prio_enc16
  import enc_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  input  logic              lsb_first,
  output logic [CODE_W-1:0] code,
  output logic              last
);

  logic found_s;
  int   idx_s;

  // Scan in priority order and latch the first set bit found.
  always_comb begin
    code    = CODE_ZERO;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < VEC_W; i++) begin
      if (lsb_first) begin
        idx_s = i;
      end else begin
        idx_s = VEC_W - 1 - i;
      end
      if (!found_s && vec[idx_s]) begin
        code    = CODE_W'(idx_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    last = (vec != VEC_ZERO) && ((vec & (vec - VEC_ONE)) == VEC_ZERO);
  end

endmodule

// File: rtl/enc16to4_seq.sv
// Serialising 16-to-4 encoder: accepts a multi-hot vector and emits one index
// per set bit with valid/ready handshakes. Optional out_par under ENC_PARITY_EN.
module enc16to4_seq
  import enc_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              busy
`ifdef ENC_PARITY_EN
  ,
  output logic              out_par
`endif
);

  localparam logic LSB_FIRST_S = (LSB_FIRST != 0) ? 1'b1 : 1'b0;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [VEC_W-1:0]    pending_r;
  logic [VEC_W-1:0]    pending_nxt_s;
  logic [CODE_W-1:0]   out_code_r;
  logic                out_last_r;
  logic                out_valid_r;
  logic                valid_nxt_s;
  logic [CODE_W-1:0]   code_nxt_s;
  logic                last_nxt_s;

  // Outputs are registered from the next pending vector, so the selected
  // index of the current pending vector is always out_code_r itself.
  prio_enc16 u_prio (
    .vec       (pending_nxt_s),
    .lsb_first (LSB_FIRST_S),
    .code      (code_nxt_s),
    .last      (last_nxt_s)
  );

  // Next-state and pending-vector update.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          pending_nxt_s = in_vec;
          if (in_vec != VEC_ZERO) begin
            state_nxt_s = ST_EMIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          pending_nxt_s = pending_r & ~(VEC_ONE << out_code_r);
          if (out_last_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_EMIT;
          end
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        pending_nxt_s = VEC_ZERO;
      end
    endcase
    valid_nxt_s = (state_nxt_s == ST_EMIT);
  end

  // State, pending vector and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pending_r   <= VEC_ZERO;
      out_valid_r <= 1'b0;
      out_code_r  <= CODE_ZERO;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pending_r   <= pending_nxt_s;
      out_valid_r <= valid_nxt_s;
      out_code_r  <= valid_nxt_s ? code_nxt_s : CODE_ZERO;
      out_last_r  <= valid_nxt_s ? last_nxt_s : 1'b0;
    end
  end

`ifdef ENC_PARITY_EN
  logic out_par_r;

  // Parity tracks the registered code and is forced low when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_par_r <= 1'b0;
    end else begin
      out_par_r <= valid_nxt_s ? even_parity(code_nxt_s) : 1'b0;
    end
  end

  assign out_par = out_par_r;
`endif

  assign out_valid = out_valid_r;
  assign out_code  = out_code_r;
  assign out_last  = out_last_r;
  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r == ST_EMIT);

endmodule

// File: tb/tb_enc16to4_seq.sv
// Bench for enc16to4_seq: both scan orders driven in parallel against a
// queue-based model of pending indices, plus directed literal scenarios.
module tb_enc16to4_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_vec;
  logic        out_ready;

  logic        in_ready_l, out_valid_l, out_last_l, busy_l;
  logic [3:0]  out_code_l;
  logic        in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [3:0]  out_code_m;
`ifdef ENC_PARITY_EN
  logic        par_l, par_m;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit cap_en = 1'b0;

  logic [3:0] q_l[$];
  logic [3:0] q_m[$];
  logic [3:0] cap_l[$];
  logic [3:0] cap_m[$];
  logic       cap_last_l[$];

  always #5 clk = ~clk;

  enc16to4_seq #(.LSB_FIRST(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_code(out_code_l), .out_last(out_last_l), .busy(busy_l)
`ifdef ENC_PARITY_EN
    , .out_par(par_l)
`endif
  );

  enc16to4_seq #(.LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_code(out_code_m), .out_last(out_last_m), .busy(busy_m)
`ifdef ENC_PARITY_EN
    , .out_par(par_m)
`endif
  );

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a vector accepted while empty becomes a list of its set-bit indices;
  // each handshake pops one; reset discards everything.
  always @(posedge clk) begin
    if (!rst_n) begin
      q_l.delete();
      q_m.delete();
    end else if (q_l.size() > 0) begin
      if (out_ready) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
    end else if (in_valid) begin
      for (int i = 0; i < 16; i++) if (in_vec[i]) q_l.push_back(4'(i));
      for (int i = 15; i >= 0; i--) if (in_vec[i]) q_m.push_back(4'(i));
    end
  end

  // Compare both DUTs against the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("valid_l", out_valid_l, q_l.size() > 0);
      cmp("valid_m", out_valid_m, q_m.size() > 0);
      cmp("in_ready_l", in_ready_l, q_l.size() == 0);
      cmp("in_ready_m", in_ready_m, q_m.size() == 0);
      cmp("busy_l", busy_l, q_l.size() > 0);
      cmp("busy_m", busy_m, q_m.size() > 0);
      if (q_l.size() > 0) begin
        cmp("code_l", out_code_l, q_l[0]);
        cmp("code_m", out_code_m, q_m[0]);
        cmp("last_l", out_last_l, q_l.size() == 1);
        cmp("last_m", out_last_m, q_m.size() == 1);
`ifdef ENC_PARITY_EN
        cmp("par_l", par_l, $countones(q_l[0]) % 2);
        cmp("par_m", par_m, $countones(q_m[0]) % 2);
      end else begin
        cmp("par_idle_l", par_l, 1'b0);
`endif
      end
    end
    if (cap_en && out_valid_l && out_ready) begin
      cap_l.push_back(out_code_l);
      cap_last_l.push_back(out_last_l);
    end
    if (cap_en && out_valid_m && out_ready) cap_m.push_back(out_code_m);
  end

  initial begin
    logic [3:0] exp_l[4];
    logic [3:0] exp_m[4];
    exp_l = '{4'd0, 4'd5, 4'd10, 4'd15};
    exp_m = '{4'd15, 4'd10, 4'd5, 4'd0};

    rst_n = 1'b0; in_valid = 1'b0; in_vec = 16'h0000; out_ready = 1'b0;
    step(); step();
    chk_en = 1'b1;
    cmp("rst_valid", out_valid_l, 1'b0);
    cmp("rst_code", out_code_l, 4'h0);
    cmp("rst_last", out_last_l, 1'b0);
    cmp("rst_busy", busy_l, 1'b0);
    cmp("rst_in_ready", in_ready_l, 1'b1);
    rst_n = 1'b1;
    step();

    // Single bit 0
    in_vec = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    cmp("one_valid", out_valid_l, 1'b1);
    cmp("one_code", out_code_l, 4'h0);
    cmp("one_last", out_last_l, 1'b1);
    step();
    cmp("one_in_ready", in_ready_l, 1'b1);
    cmp("one_idle", out_valid_l, 1'b0);

    // 16'h8421 in both orders, back to back
    cap_en = 1'b1;
    in_vec = 16'h8421; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    cap_en = 1'b0;
    cmp("seq_count_l", cap_l.size(), 4);
    cmp("seq_count_m", cap_m.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < cap_l.size()) begin
        cmp("seq_code_l", cap_l[k], exp_l[k]);
        cmp("seq_last_l", cap_last_l[k], k == 3);
      end else begin
        cmp("seq_missing_l", 16'hFFFF, exp_l[k]);
      end
      if (k < cap_m.size()) cmp("seq_code_m", cap_m[k], exp_m[k]);
      else cmp("seq_missing_m", 16'hFFFF, exp_m[k]);
    end
    step();

    // Back-pressure hold on 16'h0006
    in_vec = 16'h0006; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmp("hold_valid", out_valid_l, 1'b1);
      cmp("hold_code_l", out_code_l, 4'd1);
      cmp("hold_code_m", out_code_m, 4'd2);
      cmp("hold_last", out_last_l, 1'b0);
      if (k < 2) step();
    end
    out_ready = 1'b1;
    step();
    cmp("rel_code_l", out_code_l, 4'd2);
    cmp("rel_code_m", out_code_m, 4'd1);
    cmp("rel_last", out_last_l, 1'b1);
    step();
    cmp("rel_done", out_valid_l, 1'b0);

    // Zero vector consumed silently
    in_vec = 16'h0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cmp("zero_valid", out_valid_l, 1'b0);
    cmp("zero_in_ready", in_ready_l, 1'b1);
    step();
    cmp("zero_valid2", out_valid_l, 1'b0);

    // Reset in the middle of 16'hFFFF
    in_vec = 16'hFFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    cmp("ffff_code", out_code_l, 4'd4);
    rst_n = 1'b0;
    step();
    cmp("abort_valid", out_valid_l, 1'b0);
    cmp("abort_busy", busy_l, 1'b0);
    cmp("abort_in_ready", in_ready_l, 1'b1);
    rst_n = 1'b1;
    step();
    cmp("abort_quiet", out_valid_l, 1'b0);

`ifdef ENC_PARITY_EN
    in_vec = 16'h0088; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cmp("par_code3", out_code_l, 4'd3);
    cmp("par_bit3", par_l, 1'b0);
    step();
    cmp("par_code7", out_code_l, 4'd7);
    cmp("par_bit7", par_l, 1'b1);
    step();
`endif

    // Random traffic, checked by the compare process every cycle
    for (int n = 0; n < 600; n++) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      in_valid = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       in_vec = 16'h0000;
        1:       in_vec = 16'h0001 << $urandom_range(0, 15);
        2:       in_vec = 16'hFFFF;
        default: in_vec = 16'($urandom);
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
